dmem_ctrl: RTL and testbench

Parametrised data-memory controller for the RV64 core's MEM stage. It serves byte, half, word and double loads and stores against an internal 64-bit-wide RAM mapped at `BASE_ADDR`. Over the original single-cycle data RAM it adds:
- a configurable-latency request/done handshake;
- RISC-V sub-word store lane masking;
- load sign/zero extension;
- misalignment and out-of-range error reporting.

---
 rtl/dmem_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word/double loads and stores on a 64-bit RAM.
// Latency LATENCY+1 cycles from the accepting edge; requests seen while not IDLE are ignored, not queued.
module dmem_ctrl #(
    parameter int          DEPTH     = 8192,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    output logic [63:0] dm_dout,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  state
);
    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = $clog2(LATENCY + 1);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, complete;
    logic [2:0]    rd_q, wr_q;
    logic [63:0]   addr_q, din_q;
    logic [63:0]   mem [DEPTH];

    logic [63:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [2:0]    lane;
    logic [3:0]    nbytes;
    logic          misal, bad_op, error;
    logic [7:0]    bmask;
    logic [63:0]   wmask, wdata, rword, shifted, ld_val;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_rd_ctrl != 3'd0 || dm_wr_ctrl != 3'd0) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Range check is done on the unwrapped offset, so addresses below BASE_ADDR never alias in.
    assign off      = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (off < SPAN);
    assign idx      = off[AW+2:3];
    assign lane     = addr_q[2:0];

    always_comb begin
        nbytes = 4'd0;
        misal  = 1'b0;
        bad_op = 1'b0;
        if (wr_q != 3'd0) begin
            case (wr_q)
                3'd1:    nbytes = 4'd1;
                3'd2:    begin nbytes = 4'd2; misal = lane[0]; end
                3'd3:    begin nbytes = 4'd4; misal = (lane[1:0] != 2'd0); end
                3'd4:    begin nbytes = 4'd8; misal = (lane != 3'd0); end
                default: bad_op = 1'b1;
            endcase
        end else begin
            case (rd_q)
                3'd1, 3'd2: nbytes = 4'd1;
                3'd3, 3'd4: begin nbytes = 4'd2; misal = lane[0]; end
                3'd5, 3'd6: begin nbytes = 4'd4; misal = (lane[1:0] != 2'd0); end
                3'd7:       begin nbytes = 4'd8; misal = (lane != 3'd0); end
                default:    nbytes = 4'd0;
            endcase
        end
    end

    assign error = bad_op | misal | ~in_range;
    assign bmask = 8'((9'd1 << nbytes) - 9'd1) << lane;
    assign wdata = din_q << {lane, 3'b000};
    assign rword = mem[idx];
    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        for (int i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{bmask[i]}};
    end

    always_comb begin
        case (rd_q)
            3'd1:    ld_val = {{56{shifted[7]}}, shifted[7:0]};
            3'd2:    ld_val = {56'd0, shifted[7:0]};
            3'd3:    ld_val = {{48{shifted[15]}}, shifted[15:0]};
            3'd4:    ld_val = {48'd0, shifted[15:0]};
            3'd5:    ld_val = {{32{shifted[31]}}, shifted[31:0]};
            3'd6:    ld_val = {32'd0, shifted[31:0]};
            3'd7:    ld_val = shifted;
            default: ld_val = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (complete && wr_q != 3'd0 && !error)
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 3'd0;
            wr_q    <= 3'd0;
            addr_q  <= 64'd0;
            din_q   <= 64'd0;
            dm_dout <= 64'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= complete;
            err     <= complete & error;
            if (accept) begin
                wr_q   <= dm_wr_ctrl;
                // A simultaneous read is dropped silently when a write is present.
                rd_q   <= (dm_wr_ctrl != 3'd0) ? 3'd0 : dm_rd_ctrl;
                addr_q <= dm_addr;
                din_q  <= dm_din;
            end
            if (complete && wr_q == 3'd0)
                dm_dout <= error ? 64'd0 : ld_val;
        end
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at LATENCY=1, one at LATENCY=3, small DEPTH.
module tb_dmem_ctrl;
    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  rd1, wr1, rd3, wr3;
    logic [63:0] a1, d1, a3, d3;
    logic [63:0] dout1, dout3;
    logic        busy1, busy3, done1, done3, err1, err3;
    logic [1:0]  st1, st3;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .dm_rd_ctrl(rd1), .dm_wr_ctrl(wr1), .dm_addr(a1), .dm_din(d1),
        .dm_dout(dout1), .busy(busy1), .done(done1), .err(err1), .state(st1));

    dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .rst(rst), .dm_rd_ctrl(rd3), .dm_wr_ctrl(wr3), .dm_addr(a3), .dm_din(d3),
        .dm_dout(dout3), .busy(busy3), .done(done3), .err(err3), .state(st3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s3, input logic [2:0] rd, input logic [2:0] wr,
                         input logic [63:0] a, input logic [63:0] d);
        if (s3) begin rd3 = rd; wr3 = wr; a3 = a; d3 = d; end
        else    begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
    endtask

    // Issue one request, hold it until done, then check timing, err and optionally dm_dout.
    task automatic op(input string tag, input bit s3, input logic [2:0] rd, input logic [2:0] wr,
                      input logic [63:0] a, input logic [63:0] d, input logic exp_err,
                      input bit chk_dout, input logic [63:0] exp_dout);
        int  lat;
        int  n;
        bit  seen;
        lat  = s3 ? 3 : 1;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        drive(s3, rd, wr, a, d);
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = s3 ? done3 : done1;
        end
        chk({tag, " done seen"}, 64'(seen), 64'd1);
        chk({tag, " done edge"}, 64'(n), 64'(lat + 1));
        chk({tag, " err"}, 64'(s3 ? err3 : err1), 64'(exp_err));
        if (chk_dout) chk({tag, " dout"}, s3 ? dout3 : dout1, exp_dout);
        drive(s3, 3'd0, 3'd0, 64'd0, 64'd0);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 64'(s3 ? done3 : done1), 64'd0);
        chk({tag, " back idle"}, 64'(s3 ? st3 : st1), 64'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        drive(1'b1, 3'd0, 3'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst state", 64'(st3), 64'd0);
        chk("rst busy", 64'(busy3), 64'd0);
        chk("rst done", 64'(done3), 64'd0);
        chk("rst err", 64'(err3), 64'd0);
        chk("rst dout", dout3, 64'd0);
        chk("rst state lat1", 64'(st1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // SD then LD at both latencies
        op("sd lat1", 1'b0, 3'd0, 3'd4, BASE + 64'h10, 64'h1122334455667788, 1'b0, 1'b0, 64'd0);
        op("ld lat1", 1'b0, 3'd7, 3'd0, BASE + 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122334455667788);
        op("sd lat3", 1'b1, 3'd0, 3'd4, BASE + 64'h10, 64'h1122334455667788, 1'b0, 1'b0, 64'd0);
        op("ld lat3", 1'b1, 3'd7, 3'd0, BASE + 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122334455667788);

        // Sub-word store and extended loads
        op("sb", 1'b1, 3'd0, 3'd1, BASE + 64'h13, 64'h0000_0000_0000_AB80, 1'b0, 1'b1, 64'h1122334455667788);
        op("lb", 1'b1, 3'd1, 3'd0, BASE + 64'h13, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        op("lbu", 1'b1, 3'd2, 3'd0, BASE + 64'h13, 64'd0, 1'b0, 1'b1, 64'h80);
        op("lh", 1'b1, 3'd3, 3'd0, BASE + 64'h12, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8066);
        op("lwu", 1'b1, 3'd6, 3'd0, BASE + 64'h14, 64'd0, 1'b0, 1'b1, 64'h1122_3344);
        op("ld merged", 1'b1, 3'd7, 3'd0, BASE + 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122_3344_8066_7788);

        // Misaligned
        op("lh misal", 1'b1, 3'd3, 3'd0, BASE + 64'h1, 64'd0, 1'b1, 1'b1, 64'd0);
        op("sw misal", 1'b1, 3'd0, 3'd3, BASE + 64'h12, 64'hDEADBEEF, 1'b1, 1'b1, 64'd0);
        op("ld after sw misal", 1'b1, 3'd7, 3'd0, BASE + 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122_3344_8066_7788);
        op("reserved wr", 1'b1, 3'd0, 3'd6, BASE + 64'h10, 64'hFFFF, 1'b1, 1'b1, 64'h1122_3344_8066_7788);

        // Out of range and last word
        op("ld below", 1'b1, 3'd7, 3'd0, 64'h7FFF_FFF8, 64'd0, 1'b1, 1'b1, 64'd0);
        op("ld above", 1'b1, 3'd7, 3'd0, BASE + 64'(DEPTH) * 8, 64'd0, 1'b1, 1'b1, 64'd0);
        op("sd last", 1'b1, 3'd0, 3'd4, BASE + 64'(DEPTH - 1) * 8, 64'hCAFEBABE_0BADF00D, 1'b0, 1'b0, 64'd0);
        op("ld last", 1'b1, 3'd7, 3'd0, BASE + 64'(DEPTH - 1) * 8, 64'd0, 1'b0, 1'b1, 64'hCAFEBABE_0BADF00D);

        // Read and write together: write wins, dout untouched
        op("rd+wr", 1'b1, 3'd7, 3'd4, BASE + 64'h20, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'hCAFEBABE_0BADF00D);
        op("ld rd+wr", 1'b1, 3'd7, 3'd0, BASE + 64'h20, 64'd0, 1'b0, 1'b1, 64'h0123456789ABCDEF);

        // New request during BUSY is ignored
        @(negedge clk);
        drive(1'b1, 3'd7, 3'd0, BASE + 64'h10, 64'd0);
        @(posedge clk); #1;
        chk("busy after accept", 64'(st3), 64'd1);
        drive(1'b1, 3'd0, 3'd4, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        drive(1'b1, 3'd0, 3'd0, 64'd0, 64'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done3) pulses++;
        end
        chk("ignored req pulses", 64'(pulses), 64'd1);
        chk("ignored req dout", dout3, 64'h1122_3344_8066_7788);
        op("ld after ignore", 1'b1, 3'd7, 3'd0, BASE + 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122_3344_8066_7788);

        // Reset mid-BUSY aborts the store
        op("sd pre", 1'b1, 3'd0, 3'd4, BASE + 64'h30, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 64'd0);
        op("ld pre", 1'b1, 3'd7, 3'd0, BASE + 64'h30, 64'd0, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        drive(1'b1, 3'd0, 3'd4, BASE + 64'h30, 64'h5555_5555_5555_5555);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 3'd0, 3'd0, 64'd0, 64'd0);
        #1;
        chk("midrst state", 64'(st3), 64'd0);
        chk("midrst busy", 64'(busy3), 64'd0);
        chk("midrst done", 64'(done3), 64'd0);
        chk("midrst err", 64'(err3), 64'd0);
        chk("midrst dout", dout3, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        op("ld after rst", 1'b1, 3'd7, 3'd0, BASE + 64'h30, 64'd0, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
